ft_extremum_tracker: RTL
========================

# ft_extremum_tracker

Parametrised successor to the fingertip position detector in the IPU skin-segmentation pipeline. It consumes the cleaned skin mask stream with raw sensor X/Y counters and, per frame, tracks a selectable extreme skin pixel (leftmost, rightmost, topmost or bottommost), the skin bounding box and the skin pixel count. At end of frame it reports the registered result with a one-cycle valid pulse. It sits between the skin filter and the fingertip-to-game-cell mapper.

## Interface
- SHIFT, 1: right shift from raw counters to screen coordinates (raw = 2x screen at default)
- WIDTH, 640: screen width in screen coordinates
- HEIGHT, 480: screen height in screen coordinates
- CW, 10: width of reported coordinates
- CNT_W, 20: width of pixel counter
- MIN_PIXELS, 64: minimum skin pixel count for a valid detection
- iCLK  in  1  clock; one clock; reset is synchronous and active-high
- iRST  in  1  synchronous active-high reset
- iDCLEAN  in  1  skin mask bit for the current pixel
- iDVAL  in  1  pixel valid qualifier
- iX_Cont  in  16  raw column counter
- iY_Cont  in  16  raw row counter
- iFrame_En  in  1  tracking enable, sampled at frame start
- iMode  in  2  0 min-x, 1 max-x, 2 min-y, 3 max-y; sampled at frame start
- oFT_X, oFT_Y  out  CW  reported extreme point (screen coordinates)
- oBB_X0, oBB_X1, oBB_Y0, oBB_Y1  out  CW  reported skin bounding box
- oPIX_CNT  out  CNT_W  skin pixel count of last reported frame
- oFOUND  out  1  last reported frame had oPIX_CNT >= MIN_PIXELS
- oDVAL  out  1  one-cycle report strobe

## Operation
- Screen coords: sx = iX_Cont >> SHIFT, sy = iY_Cont >> SHIFT, truncated to CW bits.
- Frame start: iDVAL=1 with raw (0,0). Frame end: iDVAL=1 with raw X = (WIDTH<<SHIFT)-1 and raw Y = (HEIGHT<<SHIFT)-1.
- FSM states: IDLE, ACCUM, REPORT.
  - IDLE: on frame start with iFrame_En=1, latch iMode, clear accumulators, process that pixel, go ACCUM. With iFrame_En=0, stay IDLE.
  - ACCUM: process every pixel with iDVAL=1. On frame end, process that pixel, go REPORT. A frame start in ACCUM (missed end) clears the accumulators and re-latches mode/enable. No report is made, and the FSM stays in ACCUM, or goes to IDLE if iFrame_En=0.
  - REPORT: one cycle; assert oDVAL, go IDLE.
- Pixel processing, when iDVAL=1 and iDCLEAN=1:
  - Increment the count, saturating at 2^CNT_W-1.
  - Update the bounding box min/max.
  - Update the extreme point using a strict compare on the mode axis (<, or > for max modes). First pixel in raster order wins ties.
  - The first skin pixel of a frame always loads the box and the extreme point.
- Accumulator clear values: count 0, box X0/Y0 all-ones, X1/Y1 zero, extreme invalid.
- Report, updated on the REPORT cycle:
  - oPIX_CNT and oFOUND always update.
  - oFT_X/Y and the box update only when the count >= MIN_PIXELS; otherwise they hold their previous values.
- Pixels with iDVAL=0 are ignored in all states.

## Timing
- Reset: FSM goes to IDLE; all outputs go to 0; accumulators are cleared. Reset mid-frame discards the frame, and the next frame start begins fresh.
- Outputs are registered. oDVAL is high exactly one cycle, the cycle after the frame-end pixel is sampled. Results are valid in that same cycle and held until the next report.
- Frame-end and frame-start on consecutive cycles: the report occurs and the new frame is accepted. REPORT→IDLE is combined with frame-start detection, so no pixel is lost.
- Throughput: one pixel per clock, no stalls.

## Test plan
- Reset, then a 640x480 frame (SHIFT=1, raw 1280x960) with a 20x20 skin block at screen (100..119, 200..219), mode 0. Required response:
  - oDVAL pulses once, one cycle after the raw (1279,959) pixel.
  - oFT=(100,200); box (100,119,200,219); oPIX_CNT=1600 raw pixels; oFOUND=1.
- Same block, modes 1/2/3. Required response, with first-in-raster tie-break:
  - mode 1: oFT=(119,200)
  - mode 2: oFT=(100,200)
  - mode 3: oFT=(100,219)
- Frame with 10 raw skin pixels after a valid frame. Required response: oPIX_CNT=10, oFOUND=0, and oFT/box hold the previous frame's values.
- iFrame_En=0 at frame start. Required response: no oDVAL for that frame. The next enabled frame reports normally.
- Frame start injected mid-frame after 500 skin pixels, then a clean frame with one skin pixel at (5,7) and MIN_PIXELS=1. Required response: a single report with oFT=(5,7) and oPIX_CNT=1.
- iRST asserted mid-frame for 1 cycle. Required response: all outputs read 0 and no report for that frame. iMode changed mid-frame has no effect until the next frame start.

Source files
------------

// File: rtl/ft_extremum_tracker.sv
// Per-frame skin extremum / bounding-box / pixel-count tracker on a raster mask stream.
// Latency: result registers and oDVAL update on the clock edge that samples the frame-end pixel.
// Backpressure: none; one pixel per clock is accepted in every state, with no stalls.
module ft_extremum_tracker #(
    parameter int SHIFT      = 1,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int CW         = 10,
    parameter int CNT_W      = 20,
    parameter int MIN_PIXELS = 64
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iDCLEAN,
    input  logic             iDVAL,
    input  logic [15:0]      iX_Cont,
    input  logic [15:0]      iY_Cont,
    input  logic             iFrame_En,
    input  logic [1:0]       iMode,
    output logic [CW-1:0]    oFT_X,
    output logic [CW-1:0]    oFT_Y,
    output logic [CW-1:0]    oBB_X0,
    output logic [CW-1:0]    oBB_X1,
    output logic [CW-1:0]    oBB_Y0,
    output logic [CW-1:0]    oBB_Y1,
    output logic [CNT_W-1:0] oPIX_CNT,
    output logic             oFOUND,
    output logic             oDVAL
);

    localparam logic [15:0]      X_END   = 16'((WIDTH << SHIFT) - 1);
    localparam logic [15:0]      Y_END   = 16'((HEIGHT << SHIFT) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t           state, state_nxt;
    logic             frame_start, frame_end;
    logic             clr, proc, mode_ld, rpt_ld;
    logic [CW-1:0]    sx, sy;
    logic [1:0]       mode_r, mode_eff;
    logic             better, found_nxt;

    logic [CNT_W-1:0] acc_cnt, base_cnt, cnt_nxt;
    logic [CW-1:0]    acc_x0, acc_x1, acc_y0, acc_y1, acc_ftx, acc_fty;
    logic [CW-1:0]    base_x0, base_x1, base_y0, base_y1, base_ftx, base_fty;
    logic [CW-1:0]    x0_nxt, x1_nxt, y0_nxt, y1_nxt, ftx_nxt, fty_nxt;
    logic             acc_ft_vld, base_ft_vld, ft_vld_nxt;

    assign sx          = CW'(iX_Cont >> SHIFT);
    assign sy          = CW'(iY_Cont >> SHIFT);
    assign frame_start = iDVAL && (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
    assign frame_end   = iDVAL && (iX_Cont == X_END) && (iY_Cont == Y_END);
    // The frame-start pixel is compared with the mode being latched on that cycle.
    assign mode_eff    = mode_ld ? iMode : mode_r;

    // Next-state and control: a frame start with enable always opens a fresh frame, even from REPORT.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        proc      = 1'b0;
        mode_ld   = 1'b0;
        rpt_ld    = 1'b0;
        case (state)
            ACCUM: begin
                if (frame_start) begin
                    // Missed frame end: drop the partial frame without reporting.
                    clr     = 1'b1;
                    mode_ld = 1'b1;
                    if (iFrame_En) begin
                        proc = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (iDVAL) begin
                    proc = 1'b1;
                    if (frame_end) begin
                        rpt_ld    = 1'b1;
                        state_nxt = REPORT;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                if (frame_start && iFrame_En) begin
                    clr       = 1'b1;
                    proc      = 1'b1;
                    mode_ld   = 1'b1;
                    state_nxt = ACCUM;
                end
            end
        endcase
    end

    // Accumulator update for the current pixel on top of either cleared or running values.
    always_comb begin
        base_cnt    = clr ? '0 : acc_cnt;
        base_x0     = clr ? '1 : acc_x0;
        base_x1     = clr ? '0 : acc_x1;
        base_y0     = clr ? '1 : acc_y0;
        base_y1     = clr ? '0 : acc_y1;
        base_ftx    = clr ? '0 : acc_ftx;
        base_fty    = clr ? '0 : acc_fty;
        base_ft_vld = clr ? 1'b0 : acc_ft_vld;

        case (mode_eff)
            2'd0:    better = sx < base_ftx;
            2'd1:    better = sx > base_ftx;
            2'd2:    better = sy < base_fty;
            default: better = sy > base_fty;
        endcase

        cnt_nxt    = base_cnt;
        x0_nxt     = base_x0;
        x1_nxt     = base_x1;
        y0_nxt     = base_y0;
        y1_nxt     = base_y1;
        ftx_nxt    = base_ftx;
        fty_nxt    = base_fty;
        ft_vld_nxt = base_ft_vld;

        if (proc && iDCLEAN) begin
            if (base_cnt != CNT_MAX) cnt_nxt = base_cnt + CNT_W'(1);
            if (sx < base_x0) x0_nxt = sx;
            if (sx > base_x1) x1_nxt = sx;
            if (sy < base_y0) y0_nxt = sy;
            if (sy > base_y1) y1_nxt = sy;
            // Strict compare keeps the earliest pixel in raster order on ties.
            if (!base_ft_vld || better) begin
                ftx_nxt    = sx;
                fty_nxt    = sy;
                ft_vld_nxt = 1'b1;
            end
        end

        found_nxt = cnt_nxt >= MIN_CNT;
    end

    // State register, latched mode and running accumulators.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            mode_r     <= 2'd0;
            acc_cnt    <= '0;
            acc_x0     <= '1;
            acc_x1     <= '0;
            acc_y0     <= '1;
            acc_y1     <= '0;
            acc_ftx    <= '0;
            acc_fty    <= '0;
            acc_ft_vld <= 1'b0;
        end else begin
            state      <= state_nxt;
            if (mode_ld) mode_r <= iMode;
            acc_cnt    <= cnt_nxt;
            acc_x0     <= x0_nxt;
            acc_x1     <= x1_nxt;
            acc_y0     <= y0_nxt;
            acc_y1     <= y1_nxt;
            acc_ftx    <= ftx_nxt;
            acc_fty    <= fty_nxt;
            acc_ft_vld <= ft_vld_nxt;
        end
    end

    // Report registers: count/found always refresh; point and box only for a valid detection.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDVAL    <= 1'b0;
            oPIX_CNT <= '0;
            oFOUND   <= 1'b0;
            oFT_X    <= '0;
            oFT_Y    <= '0;
            oBB_X0   <= '0;
            oBB_X1   <= '0;
            oBB_Y0   <= '0;
            oBB_Y1   <= '0;
        end else begin
            oDVAL <= rpt_ld;
            if (rpt_ld) begin
                oPIX_CNT <= cnt_nxt;
                oFOUND   <= found_nxt;
                if (found_nxt) begin
                    oFT_X  <= ftx_nxt;
                    oFT_Y  <= fty_nxt;
                    oBB_X0 <= x0_nxt;
                    oBB_X1 <= x1_nxt;
                    oBB_Y0 <= y0_nxt;
                    oBB_Y1 <= y1_nxt;
                end
            end
        end
    end

endmodule
